// File: rtl/sha256_msg_schedule.sv
// SHA-256 message-schedule expander.
// Loads one 512-bit block as sixteen 32-bit words, then emits the 64 schedule
// words W[0]..W[63], one per output handshake.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_word carries a message word
//   in_ready   block accepts a word (LOAD state)
//   in_word    message word M[i], bit 0 is the MSB
//   out_valid  out_word carries a schedule word (EMIT state)
//   out_ready  consumer accepts out_word
//   out_word   schedule word W[t], bit 0 is the MSB
//   out_idx    index t of out_word
//   out_last   high with out_valid when t = 63
module sha256_msg_schedule (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:31] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] out_word,
    output logic [0:5]  out_idx,
    output logic        out_last
);

    typedef enum logic {StLoad, StEmit} state_t;

    state_t      state_q, state_d;
    logic [0:31] win_q [16];
    logic [0:31] win_d [16];
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] new_word;
    logic        in_fire, out_fire;

    function automatic logic [31:0] xor3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        return a ^ b ^ c;
    endfunction

    // Rotations are written as bit-slice swaps on the numeric value.
    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return xor3({x[6:0], x[31:7]}, {x[17:0], x[31:18]}, x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return xor3({x[16:0], x[31:17]}, {x[18:0], x[31:19]}, x >> 10);
    endfunction

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StEmit);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_word  = win_q[0];
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == 6'd63);

    // Window always holds W[t..t+15]; carry out of the MSB is dropped.
    assign new_word = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        idx_d      = idx_q;
        for (int k = 0; k < 16; k++) begin
            win_d[k] = win_q[k];
        end

        if (in_fire || out_fire) begin
            for (int k = 0; k < 15; k++) begin
                win_d[k] = win_q[k + 1];
            end
            win_d[15] = in_fire ? in_word : new_word;
        end

        unique case (state_q)
            StLoad: begin
                if (in_fire) begin
                    load_cnt_d = load_cnt_q + 4'd1;
                    if (load_cnt_q == 4'd15) begin
                        state_d    = StEmit;
                        load_cnt_d = 4'd0;
                        idx_d      = 6'd0;
                    end
                end
            end
            StEmit: begin
                if (out_fire) begin
                    idx_d = idx_q + 6'd1;
                    if (idx_q == 6'd63) begin
                        state_d    = StLoad;
                        load_cnt_d = 4'd0;
                        idx_d      = 6'd0;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StLoad;
            load_cnt_q <= 4'd0;
            idx_q      <= 6'd0;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            idx_q      <= idx_d;
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= win_d[k];
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_word;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [5:0]  out_idx;
    logic        out_last;

    typedef struct {
        logic [31:0] word;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] blk   [16];
    logic [31:0] obs_w [64];
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          total    = 0;

    always #5 clk = ~clk;

    sha256_msg_schedule dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    function automatic logic [31:0] ms0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ms1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        total++;
        fail_cnt++;
        $error("FAIL %s: observed timeout expected completion", tag);
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    endtask

    // Reference schedule from the textbook recurrence over a flat array.
    task automatic push_expected();
        logic [31:0] w [64];
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++)
            w[t] = ms1(w[t-2]) + w[t-7] + ms0(w[t-15]) + w[t-16];
        for (int t = 0; t < 64; t++) sb.push_back('{word: w[t], idx: t});
    endtask

    // Entered and left on a falling edge.
    task automatic load_block(input bit gaps, input int nwords);
        int i = 0;
        int budget = 0;
        bit acc;
        while (i < nwords) begin
            budget = budget + 1;
            if (budget > 500) begin
                timeout("load_timeout");
                break;
            end
            check("in_ready_load", in_ready, 1);
            check("out_valid_load", out_valid, 0);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_word  = $urandom;
            end else begin
                in_valid = 1'b1;
                in_word  = blk[i];
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
        end
        in_valid = 1'b0;
        if (nwords == 16) begin
            check("valid_after_16th", out_valid, 1);
            check("idx_after_16th", out_idx, 0);
        end
    endtask

    task automatic drain(input bit bp, input int stop_after);
        int          n = 0;
        int          budget = 0;
        bit          stall = 1'b0;
        logic [31:0] hw = 32'h0;
        logic [5:0]  hi = 6'h0;
        exp_t        e;
        while (n < stop_after && sb.size() > 0) begin
            budget = budget + 1;
            if (budget > 2000) begin
                timeout("drain_timeout");
                break;
            end
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bp) begin
                in_valid = 1'($urandom_range(0, 1));
                in_word  = $urandom;
            end
            check("out_valid_emit", out_valid, 1);
            check("in_ready_emit", in_ready, 0);
            if (stall) begin
                check("hold_word", out_word, hw);
                check("hold_idx", out_idx, hi);
            end
            if (out_valid && out_ready) begin
                e = sb.pop_front();
                check("word", out_word, e.word);
                check("idx", out_idx, e.idx);
                check("last", out_last, (e.idx == 63));
                obs_w[e.idx] = out_word;
                n++;
                stall = 1'b0;
            end else begin
                stall = out_valid;
                hw    = out_word;
                hi    = out_idx;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (sb.size() == 0) begin
            check("in_ready_turnaround", in_ready, 1);
            check("out_valid_turnaround", out_valid, 0);
        end
    endtask

    task automatic check_abc_kat();
        check("abc_w0", obs_w[0], 32'h61626380);
        check("abc_w15", obs_w[15], 32'h00000018);
        check("abc_w16", obs_w[16], 32'h61626380);
        check("abc_w17", obs_w[17], 32'h000F0000);
        check("abc_w18", obs_w[18], 32'h7DA86405);
        check("abc_w63", obs_w[63], 32'h12B1EDEB);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_word"}, out_word, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_last"}, out_last, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'h0;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_word", out_word, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        rst_n = 1'b1;

        // "abc" block, then the all-zero block back-to-back
        set_abc();
        push_expected();
        load_block(1'b0, 16);
        for (int i = 0; i < 64; i++) obs_w[i] = 32'hx;
        drain(1'b0, 64);
        check_abc_kat();
        set_zero();
        push_expected();
        load_block(1'b0, 16);
        drain(1'b0, 64);

        // Backpressure with IN_VALID noise during emit
        set_abc();
        push_expected();
        load_block(1'b0, 16);
        for (int i = 0; i < 64; i++) obs_w[i] = 32'hx;
        drain(1'b1, 64);
        check_abc_kat();

        // Input gaps
        set_abc();
        push_expected();
        load_block(1'b1, 16);
        for (int i = 0; i < 64; i++) obs_w[i] = 32'hx;
        drain(1'b0, 64);
        check_abc_kat();

        // Reset mid-LOAD after 7 words
        set_abc();
        load_block(1'b0, 7);
        reset_pulse("rst_load");

        // Reset mid-EMIT at t = 30
        set_abc();
        push_expected();
        load_block(1'b0, 16);
        drain(1'b0, 30);
        check("idx_before_rst", out_idx, 30);
        reset_pulse("rst_emit");

        // Full block after reset
        set_abc();
        push_expected();
        load_block(1'b0, 16);
        for (int i = 0; i < 64; i++) obs_w[i] = 32'hx;
        drain(1'b0, 64);
        check_abc_kat();

        // Back-to-back again: zeros must carry no residue from "abc"
        set_zero();
        push_expected();
        load_block(1'b0, 16);
        drain(1'b0, 64);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
